inv_key_expansion: RTL and testbench
====================================

Name: inv_key_expansion

Overview:
- Reverse-direction AES-256 key schedule for the decryption datapath.
- Loads the final 256-bit expanded key (round keys 13 and 14) and walks the schedule backwards, one 128-bit round key per accepted handshake, in order RK14, RK13, …, RK0.
- Removes the need to store all 15 round keys. Sits between the key store and the inverse-round datapath.

Parameters:
- NR, 14, number of AES-256 rounds (fixed; last round key index).

Ports:
- iClk  in  1  clock
- iRst_n  in  1  asynchronous active-low reset
- iStart  in  1  load request; honoured only in IDLE
- iKey  in  [0:255]  {RK13, RK14} = words w52..w59, big-endian bytes, w52 at bits 0:31
- iReady  in  1  consumer accepts oRoundKey this cycle
- oValid  out  1  oRoundKey/oRound valid
- oRoundKey  out  [0:127]  current round key, words w4r..w4r+3
- oRound  out  4  index r of oRoundKey (14 down to 0)
- oBusy  out  1  state != IDLE
- oDone  out  1  one-cycle pulse after RK0 accepted

Behaviour:
- State: rWin[0:255] (lower half = RK r_lo, upper half = RK r_lo+1), rOut[3:0], FSM {IDLE, RUN}.
- Reset (asynchronous, any time, including mid-sequence): FSM=IDLE, rWin=0, rOut=0, oValid=0, oDone=0, oBusy=0, oRound=0, oRoundKey=0.
- IDLE: oValid=0. If iStart=1: rWin<=iKey, rOut<=14, FSM<=RUN. iKey is sampled only on that edge.
- RUN: oValid=1. oRound=rOut.
  - oRoundKey = rWin[128:255] when rOut==14, else rWin[0:127].
- Handshake = oValid & iReady. Without a handshake, all state and outputs hold (stable under backpressure).
- On handshake in RUN:
  - rOut==14: rOut<=13; rWin unchanged (lower half is already RK13).
  - rOut==0: FSM<=IDLE, oDone<=1 for exactly one cycle.
  - Otherwise: rWin<={new0,new1,new2,new3, rWin[0:127]}; rOut<=rOut-1.
- Step function. Window words a0..a7 = w4r..w4r+7, with r=rOut:
  - new3=a7^a6
  - new2=a6^a5
  - new1=a5^a4
  - new0=a4^T(a3)
  - r even: T(x)=SubWord(x).
  - r odd: T(x)=SubWord(RotWord(x))^Rcon[(r+1)/2], where Rcon[i]={rc_i,24'h0}, rc_1..rc_7 = 01,02,04,08,10,20,40.
  - The step is purely combinational from registered rWin/rOut; no extra pipeline stage.
- Latency: iStart at edge N → oValid=1, RK14 on cycle N+1.
  - With iReady held high: 15 consecutive valid cycles, then oDone=1 and oValid=0 on the next cycle.
- Simultaneous events:
  - iStart while RUN is ignored (no restart, no error).
  - iStart in the same cycle oDone=1 (FSM already IDLE) is accepted.
- iReady while oValid=0 has no effect.
- oBusy=1 from the cycle after iStart acceptance through the last handshake; 0 when oDone=1.

Decomposition:
- Shared package aes_pkg: NR=14, word width 32, round-key width 128, rc_1..rc_7 constant table.
- Sub-module inv_key_step: combinational; inputs window[0:255] and round parity/Rcon index; output new RK[0:127].
  - Instantiates the existing sub_word, rot_word and r_con blocks.
  - r_con is driven with index (r+1)/2.
- Top module holds the FSM, counter and window register.

Test Plan:
- Reset/idle: hold iRst_n=0 then release, iStart=0 → oValid=0, oBusy=0, oDone=0, oRoundKey=0, oRound=0 for 20 cycles.
- FIPS-197 C.3 stream: iKey=4e5a6699a9f24fe07e572baacdf8cdea_24fc79ccbf0979e9371ac23c6d68de36, iReady=1. Required output:
  - cycle 1: RK14=24fc79ccbf0979e9371ac23c6d68de36
  - cycle 2: RK13=4e5a6699a9f24fe07e572baacdf8cdea
  - RK2=a573c29fa176c498a97fce93a572c09c
  - RK1=101112131415161718191a1b1c1d1e1f
  - RK0=000102030405060708090a0b0c0d0e0f
  - oRound counts 14..0, then oDone pulse.
- Backpressure: same key, iReady random 50% → identical 15-key sequence; oRoundKey/oRound stable on every cycle with oValid=1 & iReady=0.
- Ignored restart: iStart with a different key while rOut=7 → sequence continues unchanged to RK0.
- Back-to-back: assert iStart with the C.3 key on the oDone cycle → RK14 again the following cycle.
- Async reset mid-run: drop iRst_n between clock edges at rOut=5 → oValid, oBusy, oRoundKey cleared immediately without a clock edge; after release, a fresh iStart yields the correct full sequence.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, types and byte-level lookups for the key-schedule blocks.
package aes_pkg;

  localparam int unsigned NR         = 14;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned RK_W       = 128;
  localparam int unsigned WIN_W      = 2 * RK_W;
  localparam int unsigned ROUND_W    = 4;
  localparam int unsigned RCON_IDX_W = 3;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [RK_W-1:0]   rk_t;

  // Two adjacent round keys; lo occupies the MSBs (first word of the big-endian window).
  typedef struct packed {
    rk_t lo;
    rk_t hi;
  } win_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // rc_1..rc_7, rc_1 in the MSB byte.
  localparam logic [55:0] RC_TBL = 56'h01_02_04_08_10_20_40;

  // Forward S-box, entry 0x00 in the MSB byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  // Index 0 has no round constant and yields zero.
  function automatic logic [7:0] rc_byte(input logic [RCON_IDX_W-1:0] idx);
    if (idx == '0) return 8'h00;
    return RC_TBL[(7 - int'(idx)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/inv_key_step.sv
// One backward step of the AES-256 schedule: window RK r, RK r+1 -> RK r-1.
module inv_key_step
  import aes_pkg::*;
(
  input  logic [WIN_W-1:0]      win_i,
  input  logic                  odd_i,
  input  logic [RCON_IDX_W-1:0] rcon_idx_i,
  output logic [RK_W-1:0]       rk_o
);

  word_t a3, a4, a5, a6, a7;
  word_t rot, sub_in, sub_out, rcon, t_word;
  logic  unused_win;

  assign a3 = win_i[159:128];
  assign a4 = win_i[127:96];
  assign a5 = win_i[95:64];
  assign a6 = win_i[63:32];
  assign a7 = win_i[31:0];

  // Words a0..a2 never feed the recurrence.
  assign unused_win = ^win_i[255:160];

  rot_word u_rot_word (
    .word_i (a3),
    .word_o (rot)
  );

  // One shared S-box row; odd rounds substitute the rotated word.
  assign sub_in = odd_i ? rot : a3;

  sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  r_con u_r_con (
    .idx_i  (rcon_idx_i),
    .rcon_o (rcon)
  );

  assign t_word = sub_out ^ (odd_i ? rcon : '0);
  assign rk_o   = {a4 ^ t_word, a5 ^ a4, a6 ^ a5, a7 ^ a6};

endmodule

// File: rtl/r_con.sv
// Round constant word {rc_i, 24'h0}; index 0 returns zero.
module r_con
  import aes_pkg::*;
(
  input  logic [RCON_IDX_W-1:0] idx_i,
  output logic [WORD_W-1:0]     rcon_o
);

  assign rcon_o = {rc_byte(idx_i), 24'h000000};

endmodule

// File: rtl/rot_word.sv
// RotWord: cyclic left rotation of a word by one byte.
module rot_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  assign word_o = {word_i[WORD_W-9:0], word_i[WORD_W-1 -: 8]};

endmodule

// File: rtl/sub_word.sv
// SubWord: S-box applied to each byte of a 32-bit word.
module sub_word
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] word_o
);

  assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                   sbox(word_i[15:8]),  sbox(word_i[7:0])};

endmodule

// File: rtl/inv_key_expansion.sv
// Reverse AES-256 key schedule: loads RK13/RK14 and emits RK14..RK0, one per handshake.
module inv_key_expansion
  import aes_pkg::*;
(
  input  logic               iClk,
  input  logic               iRst_n,
  input  logic               iStart,
  input  logic [WIN_W-1:0]   iKey,
  input  logic               iReady,
  output logic               oValid,
  output logic [RK_W-1:0]    oRoundKey,
  output logic [ROUND_W-1:0] oRound,
  output logic               oBusy,
  output logic               oDone
);

  state_e                 state_q, state_d;
  win_t                   win_q, win_d;
  logic [ROUND_W-1:0]     out_q, out_d;
  rk_t                    rk_q, rk_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   hs;
  logic [RCON_IDX_W-1:0]  rcon_idx;
  rk_t                    step_rk;

  assign hs       = valid_q & iReady;
  assign rcon_idx = RCON_IDX_W'((5'(out_q) + 5'd1) >> 1);

  inv_key_step u_inv_key_step (
    .win_i      (win_q),
    .odd_i      (out_q[0]),
    .rcon_idx_i (rcon_idx),
    .rk_o       (step_rk)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    out_d   = out_q;
    rk_d    = rk_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = RUN;
          win_d   = win_t'(iKey);
          out_d   = ROUND_W'(NR);
          rk_d    = iKey[RK_W-1:0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (hs) begin
          if (out_q == ROUND_W'(NR)) begin
            // Lower half already holds RK13; no schedule step needed.
            out_d = out_q - ROUND_W'(1);
            rk_d  = win_q.lo;
          end else if (out_q == '0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            win_d.lo = step_rk;
            win_d.hi = win_q.lo;
            out_d    = out_q - ROUND_W'(1);
            rk_d     = step_rk;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      out_q   <= '0;
      rk_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      out_q   <= out_d;
      rk_q    <= rk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oValid    = valid_q;
  assign oRoundKey = rk_q;
  assign oRound    = out_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;

endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: forward AES-256 expansion with an algebraic S-box as reference.
module tb_inv_key_expansion;

  logic         iClk = 1'b0;
  logic         iRst_n, iStart, iReady;
  logic [255:0] iKey;
  logic         oValid, oBusy, oDone;
  logic [127:0] oRoundKey;
  logic [3:0]   oRound;

  int errors = 0;
  int checks = 0;

  localparam logic [255:0] C3_CIPHER = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] C3_KEY    = 256'h4e5a6699a9f24fe07e572baacdf8cdea24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RK14_C    = 128'h24fc79ccbf0979e9371ac23c6d68de36;
  localparam logic [127:0] RK13_C    = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
  localparam logic [127:0] RK2_C     = 128'ha573c29fa176c498a97fce93a572c09c;
  localparam logic [127:0] RK1_C     = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] RK0_C     = 128'h000102030405060708090a0b0c0d0e0f;

  inv_key_expansion dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .iKey      (iKey),
    .iReady    (iReady),
    .oValid    (oValid),
    .oRoundKey (oRoundKey),
    .oRound    (oRound),
    .oBusy     (oBusy),
    .oDone     (oDone)
  );

  always #5 iClk = ~iClk;

  // ---------------- reference model ----------------
  logic [31:0] w [60];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s, t;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    s = inv ^ 8'h63;
    t = inv;
    for (int i = 0; i < 4; i++) begin
      t = {t[6:0], t[7]};
      s ^= t;
    end
    return s;
  endfunction

  function automatic logic [31:0] subword_ref(input logic [31:0] x);
    return {sbox_ref(x[31:24]), sbox_ref(x[23:16]), sbox_ref(x[15:8]), sbox_ref(x[7:0])};
  endfunction

  task automatic build_schedule(input logic [255:0] ck);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = ck[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t  = subword_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (i % 8 == 4) begin
        t = subword_ref(t);
      end
      w[i] = w[i-8] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [255:0] dut_key();
    return {w[52], w[53], w[54], w[55], w[56], w[57], w[58], w[59]};
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick;
    @(posedge iClk);
    #1;
  endtask

  task automatic start(input logic [255:0] k);
    iStart = 1'b1;
    iKey   = k;
    tick;
    iStart = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    iRst_n = 1'b0; iStart = 1'b0; iReady = 1'b0; iKey = '0;
    repeat (3) tick;
    checks++;
    if ({oValid, oBusy, oDone, oRound, oRoundKey} !== '0) begin
      errors++;
      $display("FAIL reset_held: v=%b b=%b d=%b r=%0d k=%h, expected all zero", oValid, oBusy, oDone, oRound, oRoundKey);
    end
    iRst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      iReady = 1'($urandom_range(0, 1));
      iKey   = rand256();
      checks++;
      if ({oValid, oBusy, oDone, oRound, oRoundKey} !== '0) begin
        errors++;
        $display("FAIL idle_c%0d: v=%b b=%b d=%b r=%0d k=%h, expected all zero", c, oValid, oBusy, oDone, oRound, oRoundKey);
      end
      tick;
    end
    iReady = 1'b0;
  endtask

  task automatic test_c3_stream;
    int r;
    logic [127:0] kat;
    bit has_kat;
    build_schedule(C3_CIPHER);
    iReady = 1'b1;
    start(C3_KEY);
    for (int k = 0; k < 15; k++) begin
      r = 14 - k;
      checks++;
      if (oValid !== 1'b1 || oBusy !== 1'b1 || oDone !== 1'b0) begin
        errors++;
        $display("FAIL c3_flags r=%0d: v=%b b=%b d=%b, expected 1 1 0", r, oValid, oBusy, oDone);
      end
      checks++;
      if (oRound !== 4'(r)) begin
        errors++;
        $display("FAIL c3_round: got %0d expected %0d", oRound, r);
      end
      checks++;
      if (oRoundKey !== exp_rk(r)) begin
        errors++;
        $display("FAIL c3_model_rk%0d: got %h expected %h", r, oRoundKey, exp_rk(r));
      end
      has_kat = 1'b1;
      case (r)
        14: kat = RK14_C;
        13: kat = RK13_C;
        2:  kat = RK2_C;
        1:  kat = RK1_C;
        0:  kat = RK0_C;
        default: begin kat = '0; has_kat = 1'b0; end
      endcase
      if (has_kat) begin
        checks++;
        if (oRoundKey !== kat) begin
          errors++;
          $display("FAIL c3_vector_rk%0d: got %h expected %h", r, oRoundKey, kat);
        end
      end
      tick;
    end
    checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL c3_done: d=%b v=%b b=%b, expected 1 0 0", oDone, oValid, oBusy);
    end
    tick;
    checks++;
    if (oDone !== 1'b0 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL c3_done_pulse: d=%b v=%b, expected 0 0", oDone, oValid);
    end
    iReady = 1'b0;
  endtask

  task automatic test_backpressure(input logic [255:0] cipher, input string tag);
    int r, cyc;
    logic [127:0] pk;
    logic [3:0] pr;
    bit stalled;
    build_schedule(cipher);
    iReady = 1'b0;
    start(dut_key());
    r = 14; cyc = 0; stalled = 1'b0; pk = '0; pr = '0;
    while (r >= 0 && cyc < 300) begin
      checks++;
      if (oValid !== 1'b1 || oRound !== 4'(r) || oRoundKey !== exp_rk(r)) begin
        errors++;
        $display("FAIL bp_%s_seq: v=%b r=%0d k=%h, expected v=1 r=%0d k=%h", tag, oValid, oRound, oRoundKey, r, exp_rk(r));
      end
      if (stalled) begin
        checks++;
        if (oRoundKey !== pk || oRound !== pr) begin
          errors++;
          $display("FAIL bp_%s_stable: r=%0d k=%h, expected held r=%0d k=%h", tag, oRound, oRoundKey, pr, pk);
        end
      end
      pk = oRoundKey;
      pr = oRound;
      iReady  = 1'($urandom_range(0, 1));
      stalled = !iReady;
      if (iReady) r--;
      tick;
      cyc++;
    end
    iReady = 1'b0;
    checks++;
    if (r >= 0) begin
      errors++;
      $display("FAIL bp_%s_timeout: %0d keys left, expected 0", tag, r + 1);
    end
    checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL bp_%s_done: d=%b v=%b b=%b, expected 1 0 0", tag, oDone, oValid, oBusy);
    end
    tick;
  endtask

  task automatic test_ignored_restart;
    int r;
    build_schedule(rand256());
    iReady = 1'b1;
    start(dut_key());
    for (int k = 0; k < 15; k++) begin
      r = 14 - k;
      checks++;
      if (oValid !== 1'b1 || oRound !== 4'(r) || oRoundKey !== exp_rk(r)) begin
        errors++;
        $display("FAIL restart_seq: v=%b r=%0d k=%h, expected v=1 r=%0d k=%h", oValid, oRound, oRoundKey, r, exp_rk(r));
      end
      iStart = (r == 7);
      if (r == 7) iKey = ~dut_key();
      tick;
    end
    iStart = 1'b0;
    checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL restart_done: d=%b v=%b, expected 1 0", oDone, oValid);
    end
    tick;
    iReady = 1'b0;
  endtask

  task automatic test_back_to_back;
    build_schedule(C3_CIPHER);
    iReady = 1'b1;
    start(C3_KEY);
    repeat (15) tick;
    checks++;
    if (oDone !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_done: d=%b expected 1", oDone);
    end
    start(C3_KEY);
    checks++;
    if (oValid !== 1'b1 || oRound !== 4'd14 || oRoundKey !== RK14_C || oDone !== 1'b0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: v=%b r=%0d k=%h d=%b b=%b, expected 1 14 %h 0 1", oValid, oRound, oRoundKey, oDone, oBusy, RK14_C);
    end
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (oRoundKey !== exp_rk(14 - k) || oRound !== 4'(14 - k)) begin
        errors++;
        $display("FAIL b2b_seq: r=%0d k=%h expected r=%0d k=%h", oRound, oRoundKey, 14 - k, exp_rk(14 - k));
      end
      tick;
    end
    checks++;
    if (oDone !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_done: d=%b expected 1", oDone);
    end
    tick;
    iReady = 1'b0;
  endtask

  task automatic test_async_reset;
    build_schedule(rand256());
    iReady = 1'b1;
    start(dut_key());
    repeat (9) tick;
    checks++;
    if (oRound !== 4'd5 || oRoundKey !== exp_rk(5)) begin
      errors++;
      $display("FAIL arst_pre: r=%0d k=%h expected r=5 k=%h", oRound, oRoundKey, exp_rk(5));
    end
    #2 iRst_n = 1'b0;
    #1;
    checks++;
    if ({oValid, oBusy, oDone, oRound, oRoundKey} !== '0) begin
      errors++;
      $display("FAIL arst_immediate: v=%b b=%b d=%b r=%0d k=%h, expected all zero", oValid, oBusy, oDone, oRound, oRoundKey);
    end
    repeat (2) tick;
    iRst_n = 1'b1;
    tick;
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL arst_idle: v=%b b=%b expected 0 0", oValid, oBusy);
    end
    build_schedule(rand256());
    start(dut_key());
    for (int k = 0; k < 15; k++) begin
      checks++;
      if (oValid !== 1'b1 || oRound !== 4'(14 - k) || oRoundKey !== exp_rk(14 - k)) begin
        errors++;
        $display("FAIL arst_fresh: v=%b r=%0d k=%h expected v=1 r=%0d k=%h", oValid, oRound, oRoundKey, 14 - k, exp_rk(14 - k));
      end
      tick;
    end
    checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL arst_done: d=%b v=%b expected 1 0", oDone, oValid);
    end
    tick;
    iReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_c3_stream();
    test_backpressure(C3_CIPHER, "c3");
    for (int i = 0; i < 3; i++) test_backpressure(rand256(), "rand");
    test_ignored_restart();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
